// File: rtl/alu.sv
// Registered ALU: three opcode tables chosen by a_en/b_en, one-cycle latency into C.
// Define ALU_SATURATE_EN to clamp arithmetic results to the signed range instead of wrapping.
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             a_en,
  input  logic             b_en,
  input  logic [2:0]       a_op,
  input  logic [1:0]       b_op,
  input  logic             ALU_en,
  output logic [WIDTH-1:0] C
);

`ifdef ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Arithmetic is done one bit wider; disagreeing top two bits mean signed overflow.
  function automatic logic [WIDTH-1:0] arith(input logic [WIDTH:0] full);
    if (SAT && (full[WIDTH] != full[WIDTH-1]))
      return full[WIDTH] ? MAX_NEG : MAX_POS;
    return full[WIDTH-1:0];
  endfunction

  logic [WIDTH:0]   a_x, b_x;
  logic [WIDTH:0]   sum_w, diff_w, dec_w, inc2_w;
  logic [WIDTH-1:0] nxt;
  logic             load;

  assign a_x    = {A[WIDTH-1], A};
  assign b_x    = {B[WIDTH-1], B};
  assign sum_w  = a_x + b_x;
  assign diff_w = a_x - b_x;
  assign dec_w  = a_x - (WIDTH+1)'(1);
  assign inc2_w = b_x + (WIDTH+1)'(2);

  always_comb begin
    load = 1'b0;
    nxt  = '0;
    if (ALU_en) begin
      case ({a_en, b_en})
        2'b10: begin
          load = 1'b1;
          case (a_op)
            3'd0:    nxt = arith(sum_w);
            3'd1:    nxt = arith(diff_w);
            3'd2:    nxt = A ^ B;
            3'd3:    nxt = A & B;
            3'd4:    nxt = A & B;
            3'd5:    nxt = A | B;
            3'd6:    nxt = ~(A ^ B);
            default: load = 1'b0;
          endcase
        end
        2'b01: begin
          load = 1'b1;
          case (b_op)
            2'd0:    nxt = ~(A & B);
            2'd1:    nxt = arith(sum_w);
            2'd2:    nxt = arith(sum_w);
            default: load = 1'b0;
          endcase
        end
        2'b11: begin
          load = 1'b1;
          case (b_op)
            2'd0:    nxt = A ^ B;
            2'd1:    nxt = ~(A ^ B);
            2'd2:    nxt = arith(dec_w);
            default: nxt = arith(inc2_w);
          endcase
        end
        default: load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      C <= '0;
    else if (load)
      C <= nxt;
  end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: driver pushes hand-computed results, monitor pops and checks C each cycle.
module tb_alu;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] A, B;
  logic         a_en, b_en, ALU_en;
  logic [2:0]   a_op;
  logic [1:0]   b_op;
  logic [W-1:0] C;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .a_en(a_en), .b_en(b_en),
    .a_op(a_op), .b_op(b_op), .ALU_en(ALU_en), .C(C)
  );

  always #5 clk = ~clk;

`ifdef ALU_SATURATE_EN
  localparam logic [W-1:0] B2_INC_EXP = 8'h7F;
  localparam logic [W-1:0] OVF_ADD    = 8'h7F;
  localparam logic [W-1:0] OVF_SUB    = 8'h80;
  localparam logic [W-1:0] OVF_DEC    = 8'h80;
`else
  localparam logic [W-1:0] B2_INC_EXP = 8'h80;
  localparam logic [W-1:0] OVF_ADD    = 8'h80;
  localparam logic [W-1:0] OVF_SUB    = 8'h7F;
  localparam logic [W-1:0] OVF_DEC    = 8'h7F;
`endif

  // Apply one cycle of inputs and queue the value C must hold after the next edge.
  task automatic drive(input logic rn, input logic en, input logic ae, input logic be,
                       input logic [2:0] aop, input logic [1:0] bop,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input string name);
    @(negedge clk);
    rst_n = rn; ALU_en = en; a_en = ae; b_en = be;
    a_op = aop; b_op = bop; A = a; B = b;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (C !== e) begin
        errors++;
        $display("FAIL %s: C=%h expected %h", n, C, e);
      end
    end
  end

  initial begin
    rst_n = 1'b0; ALU_en = 1'b0; a_en = 1'b0; b_en = 1'b0;
    a_op = '0; b_op = '0; A = '0; B = '0;

    drive(0, 1, 1, 0, 3'd0, 2'd0, 8'd0, 8'd0, 8'h00, "reset_init");
    drive(1, 1, 1, 0, 3'd0, 2'd0, 8'd1, 8'd1, 8'h02, "preload");
    drive(0, 1, 1, 0, 3'd0, 2'd0, 8'd3, 8'd4, 8'h00, "reset_priority");
    drive(1, 1, 1, 0, 3'd0, 2'd0, 8'd3, 8'd4, 8'h07, "reset_release");

    drive(1, 1, 1, 0, 3'd0, 2'd2, 8'h5A, 8'h0F, 8'h69, "a_add");
    drive(1, 1, 1, 0, 3'd1, 2'd1, 8'h5A, 8'h0F, 8'h4B, "a_sub");
    drive(1, 1, 1, 0, 3'd2, 2'd3, 8'h5A, 8'h0F, 8'h55, "a_xor");
    drive(1, 1, 1, 0, 3'd3, 2'd0, 8'h5A, 8'h0F, 8'h0A, "a_and3");
    drive(1, 1, 1, 0, 3'd0, 2'd0, 8'h5A, 8'h0F, 8'h69, "a_add_again");
    drive(1, 1, 1, 0, 3'd4, 2'd0, 8'h5A, 8'h0F, 8'h0A, "a_and4");
    drive(1, 1, 1, 0, 3'd5, 2'd0, 8'h5A, 8'h0F, 8'h5F, "a_or");
    drive(1, 1, 1, 0, 3'd6, 2'd0, 8'h5A, 8'h0F, 8'hAA, "a_xnor");
    drive(1, 1, 1, 0, 3'd7, 2'd0, 8'h11, 8'h22, 8'hAA, "a_nop");

    drive(1, 1, 0, 1, 3'($urandom_range(0, 7)), 2'd0, 8'hF0, 8'h3C, 8'hCF, "b1_nand");
    drive(1, 1, 0, 1, 3'($urandom_range(0, 7)), 2'd1, 8'hF0, 8'h3C, 8'h2C, "b1_add1");
    drive(1, 1, 0, 1, 3'($urandom_range(0, 7)), 2'd0, 8'hF0, 8'h3C, 8'hCF, "b1_nand2");
    drive(1, 1, 0, 1, 3'($urandom_range(0, 7)), 2'd2, 8'hF0, 8'h3C, 8'h2C, "b1_add2");
    drive(1, 1, 0, 1, 3'($urandom_range(0, 7)), 2'd3, 8'h01, 8'h02, 8'h2C, "b1_nop");

    drive(1, 1, 1, 1, 3'($urandom_range(0, 7)), 2'd0, 8'h10, 8'h7E, 8'h6E, "b2_xor");
    drive(1, 1, 1, 1, 3'($urandom_range(0, 7)), 2'd1, 8'h10, 8'h7E, 8'h91, "b2_xnor");
    drive(1, 1, 1, 1, 3'($urandom_range(0, 7)), 2'd2, 8'h10, 8'h7E, 8'h0F, "b2_dec");
    drive(1, 1, 1, 1, 3'($urandom_range(0, 7)), 2'd3, 8'h10, 8'h7E, B2_INC_EXP, "b2_inc2");
    drive(1, 1, 1, 1, 3'd0, 2'd2, 8'h80, 8'h00, OVF_DEC, "b2_dec_ovf");

    drive(1, 1, 1, 0, 3'd0, 2'd0, 8'h5A, 8'h0F, 8'h69, "hold_setup");
    for (int i = 0; i < 4; i++)
      drive(1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 6)), 2'($urandom_range(0, 2)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'h69, "hold_alu_en0");
    drive(1, 0, 1, 0, 3'd0, 2'd0, 'x, 'x, 8'h69, "hold_x_inputs");
    drive(1, 1, 0, 0, 3'd0, 2'd0, 8'h12, 8'h34, 8'h69, "hold_no_table");
    drive(1, 1, 0, 0, 3'd5, 2'd1, 8'hFF, 8'hFF, 8'h69, "hold_no_table2");

    drive(1, 1, 1, 0, 3'd0, 2'd0, 8'h7F, 8'h01, OVF_ADD, "ovf_add");
    drive(1, 1, 1, 0, 3'd1, 2'd0, 8'h80, 8'h01, OVF_SUB, "ovf_sub");
    drive(1, 1, 1, 0, 3'd0, 2'd0, 8'h80, 8'hFF, OVF_SUB, "ovf_add_neg");
    drive(1, 1, 1, 0, 3'd0, 2'd0, 8'hFE, 8'hFD, 8'hFB, "add_neg_no_ovf");

    @(negedge clk);
    ALU_en = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Registered combinational-op arithmetic/logic unit with one-cycle latency.
- Two operand buses A and B, and three enables (ALU_en, a_en, b_en) that select one of three opcode tables indexed by a_op or b_op.
- Leaf block driven directly by the verification interface and test environment; no downstream handshake.

Parameters:
- WIDTH, 8, bit width of A, B and C (two's-complement signed).

Ports:
- clk     input   1      rising-edge clock
- rst_n   input   1      synchronous, active-low reset
- A       input   WIDTH  operand A, signed
- B       input   WIDTH  operand B, signed
- a_en    input   1      enables opcode table A (alone) or table B2 (with b_en)
- b_en    input   1      enables opcode table B1 (alone) or table B2 (with a_en)
- a_op    input   3      opcode for table A
- b_op    input   2      opcode for tables B1/B2
- ALU_en  input   1      global enable; 0 = hold
- C       output  WIDTH  registered result, signed

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst_n). All state updates on the rising edge of clk.
- rst_n=0 sampled at an edge: C <= 0. Reset has priority over every other input, including mid-stream operation.
- Latency: inputs sampled at edge N appear on C after edge N (one cycle). No internal pipeline beyond the C register.
- Hold: C keeps its value when any of these holds:
  - ALU_en=0
  - a_en=0 and b_en=0
  - the selected opcode is a NOP
- Table A (ALU_en=1, a_en=1, b_en=0), by a_op:
  - 0: A+B
  - 1: A-B
  - 2: A^B
  - 3: A&B
  - 4: A&B
  - 5: A|B
  - 6: ~(A^B)
  - 7: NOP
- Table B1 (ALU_en=1, a_en=0, b_en=1), by b_op:
  - 0: ~(A&B)
  - 1: A+B
  - 2: A+B
  - 3: NOP
- Table B2 (ALU_en=1, a_en=1, b_en=1), by b_op:
  - 0: A^B
  - 1: ~(A^B)
  - 2: A-1
  - 3: B+2
- Unselected opcode inputs are don't-care, e.g. a_op is ignored in B1/B2.
- Arithmetic is WIDTH-bit two's complement. Carry and overflow are discarded (wrap-around), e.g. 127+1 = -128 and -128-1 = 127.
- Logic ops are bitwise across all WIDTH bits.
- X/Z on inputs while in hold: C is unaffected.

Optional Feature:
- Macro ALU_SATURATE_EN.
- Defined: every arithmetic op (A+B, A-B, A-1, B+2) saturates to the signed range. Positive overflow gives 2^(WIDTH-1)-1 (127); negative overflow gives -2^(WIDTH-1) (-128). Logic ops are unchanged.
- Undefined: wrap-around as in Behaviour.
- Ports and latency are identical in both builds.

Test Plan:
- Reset: drive C to a nonzero value, then hold rst_n=0 for one edge with ALU_en=1, a_en=1, a_op=0, A=3, B=4 -> C=0 after that edge. Release reset -> C=7 one cycle later.
- Table A sweep: A=8'h5A, B=8'h0F, a_en=1, b_en=0, a_op=0..6 -> C = 8'h69, 8'h4B, 8'h55, 8'h0A, 8'h0A, 8'h5F, 8'hAA, each one cycle after its op. a_op=7 -> C holds 8'hAA.
- Table B1 sweep: A=8'hF0, B=8'h3C, a_en=0, b_en=1, b_op=0..3 -> C = 8'hCF, 8'h2C, 8'h2C, then held at 8'h2C.
- Table B2 sweep: A=8'h10, B=8'h7E, a_en=1, b_en=1, b_op=0..3 -> C = 8'h6E, 8'h91, 8'h0F, then B+2 = 8'h80 (wrap; 8'h7F with ALU_SATURATE_EN).
- Hold conditions: after C=8'h69, set ALU_en=0 with random ops -> C stays 8'h69. Set ALU_en=1, a_en=b_en=0 -> C stays 8'h69.
- Overflow: A=127, B=1, a_op=0 -> C=-128 (127 with ALU_SATURATE_EN). A=-128, B=1, a_op=1 -> C=127 (-128 with ALU_SATURATE_EN).
